// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin burst arbiter sharing one FIFO write port
// Grants are held until req_last or MaxBurst beats, so each burst lands contiguously.
module fifo_write_arbiter #(
  parameter int NReq     = 4,
  parameter int Width    = 32,
  parameter int MaxBurst = 8,
  localparam int IdWidth = $clog2(NReq)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NReq-1:0]         req_valid,
  input  logic [NReq*Width-1:0]   req_data,
  input  logic [NReq-1:0]         req_last,
  output logic [NReq-1:0]         req_ready,
  output logic                    out_valid,
  output logic [Width-1:0]        out_data,
  output logic [IdWidth-1:0]      out_id,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic                    busy
);

  localparam int CntW = $clog2(MaxBurst);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e              state_q;
  logic [IdWidth-1:0]  grant_q;
  logic [IdWidth-1:0]  last_grant_q;
  logic [CntW-1:0]     beat_cnt_q;

  logic [IdWidth-1:0]  winner;
  logic                any_req;
  logic                hs;
  int                  idx;

  // Scan offsets from farthest to nearest so the requester closest after
  // last_grant_q is the final (winning) assignment.
  always_comb begin
    winner  = last_grant_q;
    any_req = 1'b0;
    idx     = 0;
    for (int k = NReq; k >= 1; k--) begin
      idx = int'(last_grant_q) + k;
      if (idx >= NReq) idx = idx - NReq;
      if (req_valid[idx[IdWidth-1:0]]) begin
        winner  = idx[IdWidth-1:0];
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    out_valid = 1'b0;
    req_ready = '0;
    out_last  = 1'b0;
    if (state_q == GRANT) begin
      out_valid          = req_valid[grant_q];
      req_ready[grant_q] = out_ready;
      out_last           = req_last[grant_q] | (beat_cnt_q == CntW'(MaxBurst - 1));
    end
  end

  assign out_data = req_data[grant_q*Width +: Width];
  assign out_id   = grant_q;
  assign busy     = (state_q == GRANT);
  assign hs       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      last_grant_q <= IdWidth'(NReq - 1);
      grant_q      <= '0;
      beat_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q    <= winner;
            beat_cnt_q <= '0;
            state_q    <= GRANT;
          end
        end
        GRANT: begin
          if (hs) begin
            if (out_last) begin
              last_grant_q <= grant_q;
              beat_cnt_q   <= '0;
              state_q      <= IDLE;
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin burst arbiter that shares a single FIFO write port among NReq requesters.
- Each requester presents a valid/ready stream with a last flag. The arbiter grants one requester at a time and forwards its beats, plus a source ID, to the FIFO write side.
- A grant is held until the requester's last beat or until MaxBurst beats, whichever comes first. This keeps each burst contiguous in the FIFO and bounds latency for the other requesters.

Parameters:
- NReq, 4, number of requesters; must be >= 2.
- Width, 32, data width per beat.
- MaxBurst, 8, maximum beats per grant; must be >= 2.
- IdWidth, $clog2(NReq), width of requester ID; derived, not overridden.

Ports:
- clk  input  1  clock; all logic on posedge.
- rstn  input  1  synchronous active-low reset.
- req_valid  input  NReq  per-requester beat valid.
- req_data  input  NReq*Width  packed data; requester i occupies [i*Width +: Width].
- req_last  input  NReq  per-requester last beat of burst.
- req_ready  output  NReq  per-requester ready; at most one bit set.
- out_valid  output  1  beat valid to FIFO write side.
- out_data  output  Width  beat data.
- out_id  output  IdWidth  index of the granted requester.
- out_last  output  1  last beat of the current grant.
- out_ready  input  1  FIFO write ready.
- busy  output  1  high while in state GRANT.

Behaviour:
- Reset (rstn low at posedge):
  - state=IDLE, last_grant=NReq-1 (so requester 0 wins first), grant=0, beat_cnt=0.
  - Reset has priority over every other event. A burst in progress is dropped with no completing handshake.
- While in IDLE, and in the cycle after reset: out_valid=0, req_ready=0, out_last=0, busy=0, out_id=grant.
- States: IDLE, GRANT.
- IDLE:
  - If any req_valid is set, pick the first set bit scanning from last_grant+1 upward, wrapping modulo NReq.
  - Register the winner as grant, clear beat_cnt, go to GRANT.
  - No request: stay in IDLE.
  - Arbitration adds one bubble cycle. Combinational paths from req_valid to out_valid exist in GRANT only.
- GRANT, with g = grant:
  - out_valid = req_valid[g], out_data = req_data[g], out_id = g.
  - req_ready[g] = out_ready; all other req_ready bits are 0.
  - out_last = req_last[g] OR (beat_cnt == MaxBurst-1).
  - Handshake is out_valid AND out_ready. On a handshake without out_last, beat_cnt increments.
  - On a handshake with out_last: last_grant <= g, beat_cnt <= 0, state <= IDLE.
- beat_cnt is $clog2(MaxBurst) bits and never exceeds MaxBurst-1.
- A grant truncated by MaxBurst ends even if req_last[g]=0. The requester's remaining beats form a new burst in a later grant.
- req_valid[g] low during GRANT: the grant is held and out_valid=0. There is no timeout; requesters must not abandon a started burst.
- Requests from non-granted requesters are ignored during GRANT and receive no ready.
- out_ready low: the beat is held; out_data and out_id stay stable while out_valid is high.
- Fairness: after requester g is served, every other pending requester is served before g again. Worst-case wait is (NReq-1)*(MaxBurst+1) handshake-available cycles.
- A single-beat burst (req_last on the first beat) occupies 2 cycles: IDLE plus GRANT.
- Requester valid/data must obey standard valid/ready rules. The arbiter does not check this.

Test Plan:
- Reset, then assert req_valid[2] with a 3-beat burst (data 0xA0,0xA1,0xA2; last on 0xA2), out_ready=1:
  - busy rises the cycle after the request.
  - out_id=2, three handshakes, out_last only on 0xA2.
  - Returns to IDLE; req_ready[0,1,3] stay 0 throughout.
- All four requesters each send 1-beat bursts continuously:
  - Grant order is 0,1,2,3,0,…
  - One beat every 2 cycles; out_id matches the order.
- Requester 1 sends a 12-beat burst with MaxBurst=8:
  - First grant carries 8 beats, out_last asserted on beat 8 (beat_cnt=7).
  - Requesters 2, 3, 0 (if pending) are served next.
  - Requester 1 then sends the remaining 4 beats with out_last on its req_last.
- Backpressure: out_ready toggles 1,0,0,1 during a grant:
  - No beat is lost or duplicated.
  - out_data and out_id are stable while out_valid=1 and out_ready=0.
  - beat_cnt advances only on handshakes.
- rstn driven low mid-burst, after 2 of 5 beats:
  - The next cycle shows out_valid=0, req_ready=0, busy=0.
  - After release, requester 0 wins if it and requester 3 both request.
- Granted requester drops req_valid for 3 cycles mid-burst:
  - out_valid=0 for those cycles.
  - Grant retained even with another requester pending; the burst then completes normally.
